proc_multicycle_param: RTL and testbench
========================================

Name: proc_multicycle_param

Overview:
- Parametrised successor of the board-level multicycle processor core.
- Same 16-bit instruction format, 8-register bank and fetch/T1/T2/T3 step machine.
- Adds generic datapath width and memory depths, a program-load port, Run-gated stalling, a HALT instruction and correct PC wrap at any IMEM depth.
- Drives the same HEX/LED debug outputs through the existing top-level wrapper.

Parameters:
DATA_W, 16, register/data-memory word width (>=8)
IMEM_DEPTH, 16, instruction words (power of 2, >=2)
DMEM_DEPTH, 8, data-memory words (power of 2, >=2)

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  synchronous, active-high; priority over everything, independent of Run
Run  in  1  1 = advance one step per clock; 0 = freeze all state
iwr_en  in  1  instruction-memory write strobe; honoured only when Run=0
iwr_addr  in  clog2(IMEM_DEPTH)  write address
iwr_data  in  16  instruction word
Done  out  1  one-cycle pulse in an instruction's final step
Halted  out  1  sticky after HALT executes
pc  out  clog2(IMEM_DEPTH)  current instruction address
stage  out  4  one-hot step: 1000 fetch, 0100 T1, 0010 T2, 0001 T3
reg_A, reg_B  out  3  decoded register fields
contentA, contentB  out  DATA_W  register values latched at fetch; contentA refreshed on write to rA
Gtmp  out  DATA_W  ALU result register
out  out  DATA_W  last value written to a register (or stored value for sd)

Behaviour:
- Instruction fields: [15:12] op, [11:9] rA, [8:6] rB, [5:0] imm.
- Opcodes:
  - 0 mv
  - 1 mvi: rA <= zero-extend {rB field, imm}
  - 2 add, 3 sub (wrap modulo 2^DATA_W)
  - 4 and
  - 5 slt (unsigned; rA <= 1/0)
  - 6 sll, 7 srl: shift amount = low clog2(DATA_W) bits of rB
  - 8 mvnz: copy only if Gtmp != 0
  - 9 ld: rA <= DMEM[rB]
  - 10 sd: DMEM[rB] <= rA
  - 11-14 nop
  - 15 HALT
- DMEM address = low clog2(DMEM_DEPTH) bits of the register value.
- Reset: RegisterBank[i]=i and DMEM[i]=i mod 2^DATA_W; IMEM retained. All outputs 0 except stage=1000; FSM at fetch.
- Latency in active (Run=1) cycles, including fetch:
  - mv, mvi, and, slt, sll, srl, mvnz, nop: 2; Done in T1.
  - ld, sd: 3; Done in T2. T1 latches the operand into tmpreg.
  - add, sub: 4. T2 computes Gtmp, T3 writes rA; Done in T3.
- Register writes take effect at the clock edge of the step that asserts Done.
- After a Done cycle the next active cycle is fetch with pc+1; pc wraps IMEM_DEPTH-1 -> 0.
- HALT: in T1 set Halted=1, no Done, FSM parks; Run is ignored until Reset.
- Run=0: no state change. Done holds its value; the bench samples Done only on Run=1 cycles.
- iwr_en with Run=1 is ignored. IMEM writes while stalled mid-instruction do not affect the already-fetched instruction.
- Reset mid-instruction: instruction is abandoned, no partial register/DMEM write.
- Reset and iwr_en in the same cycle: the write is performed and the reset takes effect.

Optional Feature:
- Macro: PROC_SIGNED_SLT_EN.
- Defined: slt and the mvnz test use two's-complement signed comparison of DATA_W values.
- Undefined: slt is unsigned; mvnz is unaffected either way.

Decomposition:
- Package proc_pkg:
  - opcode localparams OP_MV..OP_HALT
  - one-hot stage constants ST_FETCH, ST_T1, ST_T2, ST_T3
  - field-position constants
- Sub-module proc_alu: combinational, parametrised by DATA_W.
  - Inputs: op, a, b. Output: result.
  - Covers add, sub, and, slt, sll, srl.
- FSM, register bank and memories stay in the top.

Test Plan:
1. Reset; load IMEM[0]=mvi R2,5; Run=1 for 2 cycles -> Done=1 in cycle 2, out=5, R2=5, pc then 1.
2. After reset (R2=2, R3=3): add R2,R3 -> stage 1000,0100,0010,0001; Done only in 4th cycle; Gtmp=5, out=5.
3. Program sd R3,R1 then ld R0,R1 -> DMEM[1]=3 after 3 cycles; R0=3, out=3 after next 3 cycles.
4. Drop Run for 3 cycles during T2 of add -> stage/pc/Gtmp frozen; iwr_en during stall writes IMEM; Done after 1 more active cycle.
5. IMEM_DEPTH=4, four mv instructions -> after 4th Done, pc=0 and IMEM[0] refetched.
6. HALT at IMEM[1] -> Halted=1 after 4 cycles, no further Done for 10 cycles, Reset clears Halted and pc=0.

Source files
------------

// File: rtl/proc_pkg.sv
// proc_pkg: shared definitions for the parametrised multicycle processor.
//   - opcode encodings (instruction bits [15:12])
//   - one-hot debug stage codes driven on the stage output
//   - instruction field positions
//   - FSM state type and a decode helper for the T1 completion class
// Optional build macro used by the design: PROC_SIGNED_SLT_EN
package proc_pkg;

    localparam logic [3:0] OP_MV   = 4'd0;
    localparam logic [3:0] OP_MVI  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_MVNZ = 4'd8;
    localparam logic [3:0] OP_LD   = 4'd9;
    localparam logic [3:0] OP_SD   = 4'd10;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [3:0] ST_FETCH = 4'b1000;
    localparam logic [3:0] ST_T1    = 4'b0100;
    localparam logic [3:0] ST_T2    = 4'b0010;
    localparam logic [3:0] ST_T3    = 4'b0001;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RA_MSB  = 11;
    localparam int RA_LSB  = 9;
    localparam int RB_MSB  = 8;
    localparam int RB_LSB  = 6;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        S_FETCH,
        S_T1,
        S_T2,
        S_T3,
        S_HALT
    } state_t;

    // Instructions that complete (assert Done) in T1. HALT parks instead.
    function automatic logic done_in_t1(input logic [3:0] op);
        return !(op inside {OP_ADD, OP_SUB, OP_LD, OP_SD, OP_HALT});
    endfunction

endpackage

// File: rtl/proc_alu.sv
// proc_alu: combinational ALU for the multicycle processor.
// Ports:
//   op     in  4       opcode (add, sub, and, slt, sll, srl; others give 0)
//   a      in  DATA_W  first operand (rA value)
//   b      in  DATA_W  second operand (rB value); low clog2(DATA_W) bits are the shift amount
//   result out DATA_W  operation result
// Build macro: PROC_SIGNED_SLT_EN selects signed slt; otherwise unsigned.
module proc_alu
    import proc_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    localparam int SH_W = $clog2(DATA_W);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD: result = a + b;
            OP_SUB: result = a - b;
            OP_AND: result = a & b;
`ifdef PROC_SIGNED_SLT_EN
            OP_SLT: result = ($signed(a) < $signed(b)) ? DATA_W'(1) : '0;
`else
            OP_SLT: result = (a < b) ? DATA_W'(1) : '0;
`endif
            OP_SLL: result = a << b[SH_W-1:0];
            OP_SRL: result = a >> b[SH_W-1:0];
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/proc_multicycle_param.sv
// proc_multicycle_param: parametrised multicycle processor core with
// fetch/T1/T2/T3 step machine, 8-entry register bank, IMEM with a load
// port (usable while Run=0) and a small data memory.
// Ports:
//   Clock, Reset (sync, active-high), Run (1 = step, 0 = freeze)
//   iwr_en / iwr_addr / iwr_data : instruction-memory write port
//   Done    : high during an instruction's final step
//   Halted  : sticky once HALT executes, cleared by Reset
//   pc, stage (one-hot 1000/0100/0010/0001), reg_A, reg_B
//   contentA, contentB : operands latched at fetch (contentA tracks writes to rA)
//   Gtmp    : add/sub result register; out : last written/stored value
// Build macro: PROC_SIGNED_SLT_EN (signed slt and signed mvnz test).
module proc_multicycle_param
    import proc_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int IMEM_DEPTH = 16,
    parameter int DMEM_DEPTH = 8
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          Run,
    input  logic                          iwr_en,
    input  logic [$clog2(IMEM_DEPTH)-1:0] iwr_addr,
    input  logic [15:0]                   iwr_data,
    output logic                          Done,
    output logic                          Halted,
    output logic [$clog2(IMEM_DEPTH)-1:0] pc,
    output logic [3:0]                    stage,
    output logic [2:0]                    reg_A,
    output logic [2:0]                    reg_B,
    output logic [DATA_W-1:0]             contentA,
    output logic [DATA_W-1:0]             contentB,
    output logic [DATA_W-1:0]             Gtmp,
    output logic [DATA_W-1:0]             out
);

    localparam int PC_W = $clog2(IMEM_DEPTH);
    localparam int DM_W = $clog2(DMEM_DEPTH);

    logic [15:0]       r_imem [IMEM_DEPTH];
    logic [DATA_W-1:0] r_regs [8];
    logic [DATA_W-1:0] r_dmem [DMEM_DEPTH];

    state_t            r_state;
    logic [3:0]        r_stage;
    logic              r_done, r_halted;
    logic [PC_W-1:0]   r_pc;
    logic [3:0]        r_op;
    logic [8:0]        r_imm9;
    logic [2:0]        r_ra, r_rb;
    logic [DATA_W-1:0] r_ca, r_cb, r_gtmp, r_out, r_tmp;

    logic [15:0]       w_fetch;
    logic [DATA_W-1:0] w_alu, w_imm, w_wr_data;
    logic              w_wr_en, w_gnz;
    logic [DM_W-1:0]   w_daddr;
    logic [PC_W-1:0]   w_pc_next;

    assign w_fetch   = r_imem[r_pc];
    assign w_imm     = DATA_W'(r_imm9);
    assign w_daddr   = r_cb[DM_W-1:0];
    assign w_pc_next = (r_pc == PC_W'(IMEM_DEPTH - 1)) ? '0 : r_pc + PC_W'(1);
`ifdef PROC_SIGNED_SLT_EN
    assign w_gnz     = ($signed(r_gtmp) != 0);
`else
    assign w_gnz     = (r_gtmp != '0);
`endif

    proc_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (r_op),
        .a      (r_ca),
        .b      (r_cb),
        .result (w_alu)
    );

    // The load port is not reset so a program survives Reset.
    always_ff @(posedge Clock) begin
        if (iwr_en && !Run)
            r_imem[iwr_addr] <= iwr_data;
    end

    // Register-bank write for the step that completes an instruction.
    // Only add/sub ever reach T3, so T3 always writes Gtmp back.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_data = r_cb;
        case (r_state)
            S_T1: begin
                case (r_op)
                    OP_MV:   w_wr_en = 1'b1;
                    OP_MVI:  begin w_wr_en = 1'b1; w_wr_data = w_imm; end
                    OP_AND, OP_SLT, OP_SLL, OP_SRL:
                             begin w_wr_en = 1'b1; w_wr_data = w_alu; end
                    OP_MVNZ: w_wr_en = w_gnz;
                    default: w_wr_en = 1'b0;
                endcase
            end
            S_T2: begin
                if (r_op == OP_LD) begin
                    w_wr_en   = 1'b1;
                    w_wr_data = r_tmp;
                end
            end
            S_T3: begin
                w_wr_en   = 1'b1;
                w_wr_data = r_gtmp;
            end
            default: w_wr_en = 1'b0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < 8; i++)          r_regs[i] <= DATA_W'(i);
            for (int i = 0; i < DMEM_DEPTH; i++) r_dmem[i] <= DATA_W'(i);
            r_state  <= S_FETCH;
            r_stage  <= ST_FETCH;
            r_done   <= 1'b0;
            r_halted <= 1'b0;
            r_pc     <= '0;
            r_op     <= '0;
            r_imm9   <= '0;
            r_ra     <= '0;
            r_rb     <= '0;
            r_ca     <= '0;
            r_cb     <= '0;
            r_gtmp   <= '0;
            r_out    <= '0;
            r_tmp    <= '0;
        end else if (Run) begin
            if (w_wr_en) begin
                r_regs[r_ra] <= w_wr_data;
                r_ca         <= w_wr_data;
                r_out        <= w_wr_data;
            end
            case (r_state)
                S_FETCH: begin
                    r_op    <= w_fetch[OP_MSB:OP_LSB];
                    r_imm9  <= w_fetch[RB_MSB:IMM_LSB];
                    r_ra    <= w_fetch[RA_MSB:RA_LSB];
                    r_rb    <= w_fetch[RB_MSB:RB_LSB];
                    r_ca    <= r_regs[w_fetch[RA_MSB:RA_LSB]];
                    r_cb    <= r_regs[w_fetch[RB_MSB:RB_LSB]];
                    r_done  <= done_in_t1(w_fetch[OP_MSB:OP_LSB]);
                    r_state <= S_T1;
                    r_stage <= ST_T1;
                end
                S_T1: begin
                    case (r_op)
                        OP_ADD, OP_SUB: begin
                            r_state <= S_T2;
                            r_stage <= ST_T2;
                        end
                        OP_LD, OP_SD: begin
                            r_tmp   <= (r_op == OP_LD) ? r_dmem[w_daddr] : r_ca;
                            r_done  <= 1'b1;
                            r_state <= S_T2;
                            r_stage <= ST_T2;
                        end
                        OP_HALT: begin
                            // Park with stage left at T1; only Reset leaves S_HALT.
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end
                        default: begin
                            r_done  <= 1'b0;
                            r_pc    <= w_pc_next;
                            r_state <= S_FETCH;
                            r_stage <= ST_FETCH;
                        end
                    endcase
                end
                S_T2: begin
                    if (r_op == OP_LD || r_op == OP_SD) begin
                        if (r_op == OP_SD) begin
                            r_dmem[w_daddr] <= r_tmp;
                            r_out           <= r_tmp;
                        end
                        r_done  <= 1'b0;
                        r_pc    <= w_pc_next;
                        r_state <= S_FETCH;
                        r_stage <= ST_FETCH;
                    end else begin
                        r_gtmp  <= w_alu;
                        r_done  <= 1'b1;
                        r_state <= S_T3;
                        r_stage <= ST_T3;
                    end
                end
                S_T3: begin
                    r_done  <= 1'b0;
                    r_pc    <= w_pc_next;
                    r_state <= S_FETCH;
                    r_stage <= ST_FETCH;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_FETCH;
                    r_stage <= ST_FETCH;
                end
            endcase
        end
    end

    assign Done     = r_done;
    assign Halted   = r_halted;
    assign pc       = r_pc;
    assign stage    = r_stage;
    assign reg_A    = r_ra;
    assign reg_B    = r_rb;
    assign contentA = r_ca;
    assign contentB = r_cb;
    assign Gtmp     = r_gtmp;
    assign out      = r_out;

endmodule

// File: tb/tb_proc_multicycle_param.sv
// Scoreboard bench for proc_multicycle_param (DATA_W=16, IMEM_DEPTH=4, DMEM_DEPTH=8).
// Stimulus pushes the expected {out, pc} of every completing instruction;
// a monitor pops one entry per Done seen on an active cycle and checks the
// state right after that completing edge.
module tb_proc_multicycle_param;

    logic        Clock = 1'b0;
    logic        Reset, Run, iwr_en;
    logic [1:0]  iwr_addr;
    logic [15:0] iwr_data;
    logic        Done, Halted;
    logic [1:0]  pc;
    logic [3:0]  stage;
    logic [2:0]  reg_A, reg_B;
    logic [15:0] contentA, contentB, Gtmp, out;

    always #5 Clock = ~Clock;

    proc_multicycle_param #(.DATA_W(16), .IMEM_DEPTH(4), .DMEM_DEPTH(8)) dut (
        .Clock(Clock), .Reset(Reset), .Run(Run),
        .iwr_en(iwr_en), .iwr_addr(iwr_addr), .iwr_data(iwr_data),
        .Done(Done), .Halted(Halted), .pc(pc), .stage(stage),
        .reg_A(reg_A), .reg_B(reg_B), .contentA(contentA), .contentB(contentB),
        .Gtmp(Gtmp), .out(out)
    );

    typedef struct packed {
        logic [15:0] o;
        logic [1:0]  p;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic logic [15:0] enc(input int op, input int ra, input int rb, input int imm);
        return {op[3:0], ra[2:0], rb[2:0], imm[5:0]};
    endfunction

    task automatic push(input logic [15:0] o, input logic [1:0] p);
        exp_t e;
        e.o = o;
        e.p = p;
        sb.push_back(e);
    endtask

    // Inputs change 2 time units after the rising edge.
    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic run_n(input int n);
        Run = 1'b1;
        repeat (n) tick();
        Run = 1'b0;
    endtask

    task automatic load(input logic [1:0] a, input logic [15:0] w);
        Run      = 1'b0;
        iwr_en   = 1'b1;
        iwr_addr = a;
        iwr_data = w;
        tick();
        iwr_en   = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    // Monitor: a Done seen with Run=1 means the next edge completes an instruction.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (Run && Done && !Reset) begin
                @(posedge Clock);
                #1;
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_done: got completion at pc 0x%0h out 0x%0h, want none", pc, out);
                end else begin
                    e = sb.pop_front();
                    chk("done_out", out, e.o);
                    chk("done_pc", pc, e.p);
                end
            end
        end
    end

    logic [3:0]  exp_stage [4] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
    logic        exp_done  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] slt_exp;

    initial begin
`ifdef PROC_SIGNED_SLT_EN
        slt_exp = 16'd0;
`else
        slt_exp = 16'd1;
`endif
        Reset = 1'b1; Run = 1'b0; iwr_en = 1'b0; iwr_addr = '0; iwr_data = '0;
        tick();
        tick();
        Reset = 1'b0;

        // reset state
        chk("rst_stage", stage, 4'b1000);
        chk("rst_pc", pc, 0);
        chk("rst_done", Done, 0);
        chk("rst_halted", Halted, 0);
        chk("rst_out", out, 0);
        chk("rst_gtmp", Gtmp, 0);
        chk("rst_contentA", contentA, 0);

        // 1: mvi R2,5
        load(0, enc(1, 2, 0, 5));
        push(16'd5, 2'd1);
        run_n(1);
        chk("mvi_stage_t1", stage, 4'b0100);
        chk("mvi_done_t1", Done, 1);
        run_n(1);
        chk("mvi_pc", pc, 1);
        chk("mvi_stage_after", stage, 4'b1000);
        chk("mvi_r2", contentA, 5);

        // 2: add R2,R3 step sequence
        load(0, enc(2, 2, 3, 0));
        do_reset();
        push(16'd5, 2'd1);
        for (int i = 0; i < 4; i++) begin
            run_n(1);
            chk("add_stage", stage, exp_stage[i]);
            chk("add_done", Done, exp_done[i]);
        end
        chk("add_gtmp", Gtmp, 5);

        // 3: sd R3,R1 then ld R0,R1
        load(0, enc(10, 3, 1, 0));
        load(1, enc(9, 0, 1, 0));
        do_reset();
        push(16'd3, 2'd1);
        push(16'd3, 2'd2);
        run_n(2);
        chk("sd_done_t2", Done, 1);
        chk("sd_stage_t2", stage, 4'b0010);
        run_n(1);
        chk("sd_pc", pc, 1);
        run_n(3);
        chk("ld_r0", contentA, 3);
        chk("ld_pc", pc, 2);

        // 4: stall during T2 of add R4,R5 with IMEM writes
        load(0, enc(2, 4, 5, 0));
        do_reset();
        push(16'd9, 2'd1);
        run_n(2);
        chk("stall_enter_stage", stage, 4'b0010);
        load(1, enc(1, 1, 0, 7));
        load(0, enc(15, 0, 0, 0));
        tick();
        chk("stall_stage", stage, 4'b0010);
        chk("stall_pc", pc, 0);
        chk("stall_gtmp", Gtmp, 0);
        chk("stall_done", Done, 0);
        run_n(1);
        chk("resume_gtmp", Gtmp, 9);
        chk("resume_done", Done, 1);
        chk("resume_stage", stage, 4'b0001);
        run_n(1);
        push(16'd7, 2'd2);
        run_n(2);
        chk("stall_written_mvi", contentA, 7);

        // 5: pc wrap over four mv instructions
        for (int i = 0; i < 4; i++) load(2'(i), enc(0, i, 7 - i, 0));
        do_reset();
        push(16'd7, 2'd1);
        push(16'd6, 2'd2);
        push(16'd5, 2'd3);
        push(16'd4, 2'd0);
        run_n(8);
        chk("wrap_pc", pc, 0);
        run_n(1);
        chk("refetch_regA", reg_A, 0);
        chk("refetch_regB", reg_B, 7);
        push(16'd7, 2'd1);
        run_n(1);

        // ALU ops: sub wrap, slt, srl, sll
        do_reset();
        load(0, enc(3, 1, 2, 0));
        load(1, enc(5, 0, 1, 0));
        load(2, enc(7, 1, 3, 0));
        load(3, enc(6, 4, 4, 0));
        push(16'hFFFF, 2'd1);
        push(slt_exp,  2'd2);
        push(16'h1FFF, 2'd3);
        push(16'h0040, 2'd0);
        run_n(10);
        chk("alu_a_pc", pc, 0);

        // and, mvnz taken (Gtmp=0xFFFF), mvi 9-bit, nop
        load(0, enc(4, 6, 5, 0));
        load(1, enc(8, 7, 2, 0));
        load(2, enc(1, 3, 7, 63));
        load(3, enc(12, 0, 0, 0));
        push(16'd4,    2'd1);
        push(16'd2,    2'd2);
        push(16'h01FF, 2'd3);
        push(16'h01FF, 2'd0);
        run_n(8);
        chk("alu_b_pc", pc, 0);

        // 6: mvnz not taken, then HALT at IMEM[1]
        load(0, enc(8, 1, 7, 0));
        load(1, enc(15, 0, 0, 0));
        do_reset();
        push(16'd0, 2'd1);
        run_n(4);
        chk("halt_flag", Halted, 1);
        chk("halt_pc", pc, 1);
        chk("halt_done", Done, 0);
        run_n(10);
        chk("halt_hold_pc", pc, 1);
        chk("halt_hold_flag", Halted, 1);
        do_reset();
        chk("halt_clr_flag", Halted, 0);
        chk("halt_clr_pc", pc, 0);
        chk("halt_clr_stage", stage, 4'b1000);

        tick();
        tick();
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
